// File: rtl/blake2_engine_arbiter.sv
// blake2_engine_arbiter: round-robin sharing of one Blake2 engine among NUM_REQ block requesters,
// holding the grant for a whole message and sequencing init/next/final.
module blake2_engine_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BLOCK_WIDTH  = 1024,
  parameter int DIGEST_WIDTH = 512,
  parameter int DATA_LENGTH  = 64
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_first,
  input  logic [NUM_REQ-1:0]             req_last,
  input  logic [NUM_REQ*BLOCK_WIDTH-1:0] req_block,
  input  logic [NUM_REQ*DATA_LENGTH-1:0] req_length,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic [DIGEST_WIDTH-1:0]        digest,
  output logic                           err,
  input  logic                           hash_ready,
  input  logic                           digest_valid,
  input  logic [DIGEST_WIDTH-1:0]        digest_in,
  output logic                           init,
  output logic                           next,
  output logic                           final_cmd,
  output logic [BLOCK_WIDTH-1:0]         block,
  output logic [DATA_LENGTH-1:0]         data_length
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [2:0] {IDLE, CMD_INIT, GUARD, WAIT_RDY, BLOCK, WAIT_DIG} state_t;
  state_t state, state_nx;
  logic [IW-1:0] owner, ptr, sel, owner_inc;
  logic [IW:0] idx;
  logic [NUM_REQ-1:0] cand;
  logic found, start, xfer, first_pending, dig_take;
  assign cand = req_valid & req_first;
  // first candidate at or after the pointer, wrapping
  always_comb begin
    sel = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      idx = idx >= (IW+1)'(NUM_REQ) ? idx - (IW+1)'(NUM_REQ) : idx;
      if (!found && cand[idx[IW-1:0]]) begin
        sel = idx[IW-1:0];
        found = 1'b1;
      end
    end
  end
  assign start     = state == IDLE && found && hash_ready;
  assign xfer      = state == BLOCK && hash_ready && req_valid[owner];
  assign dig_take  = state == WAIT_DIG && digest_valid;
  assign owner_inc = owner == IW'(NUM_REQ-1) ? '0 : owner + IW'(1);
  assign req_ready = state == BLOCK && hash_ready ? grant : '0;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = start ? CMD_INIT : IDLE;
      CMD_INIT: state_nx = GUARD;
      GUARD:    state_nx = final_cmd ? WAIT_DIG : WAIT_RDY;
      WAIT_RDY: state_nx = hash_ready ? BLOCK : WAIT_RDY;
      BLOCK:    state_nx = xfer ? GUARD : BLOCK;
      WAIT_DIG: state_nx = digest_valid ? IDLE : WAIT_DIG;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      owner         <= '0;
      ptr           <= '0;
      grant         <= '0;
      done          <= '0;
      digest        <= '0;
      err           <= 1'b0;
      init          <= 1'b0;
      next          <= 1'b0;
      final_cmd     <= 1'b0;
      block         <= '0;
      data_length   <= '0;
      first_pending <= 1'b0;
    end else begin
      state     <= state_nx;
      init      <= start;
      next      <= xfer && !req_last[owner];
      final_cmd <= xfer && req_last[owner];
      done      <= dig_take ? grant : '0;
      if (start) begin
        owner         <= sel;
        grant         <= NUM_REQ'(1) << sel;
        first_pending <= 1'b1;
      end
      if (xfer) begin
        block         <= req_block[owner*BLOCK_WIDTH +: BLOCK_WIDTH];
        first_pending <= 1'b0;
        if (req_last[owner]) data_length <= req_length[owner*DATA_LENGTH +: DATA_LENGTH];
      end
      if (dig_take) begin
        digest <= digest_in;
        grant  <= '0;
        ptr    <= owner_inc;
      end
      // a repeated first is still processed as a continuation block
      if ((xfer && !first_pending && req_first[owner]) ||
          (digest_valid && state != WAIT_DIG) ||
          ((init || next || final_cmd) && !hash_ready)) err <= 1'b1;
    end
  end
endmodule

// File: doc/blake2_engine_arbiter.md
# blake2_engine_arbiter

Shares one Blake2 hash engine between `NUM_REQ` block-level requesters, each of which presents pre-assembled message blocks. The block arbitrates round-robin at message granularity and sequences the engine's `init`/`next`/`final` command pulses. It holds the grant for a whole multi-block message, then returns the digest to the owner. It sits between the per-channel input controllers and the hash core.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `BLOCK_WIDTH`, 1024: block width in bits.
- `DIGEST_WIDTH`, 512: digest width in bits.
- `DATA_LENGTH`, 64: message-length width.
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: requester i is presenting a block.
- `req_first` in NUM_REQ: the presented block is the first block of a message.
- `req_last` in NUM_REQ: the presented block is the last block of a message.
- `req_block` in NUM_REQ*BLOCK_WIDTH: block of requester i at slice [i*BLOCK_WIDTH +: BLOCK_WIDTH].
- `req_length` in NUM_REQ*DATA_LENGTH: total message length, valid with `req_last`.
- `req_ready` out NUM_REQ: block accepted when `req_valid & req_ready`.
- `grant` out NUM_REQ: one-hot current owner; 0 when idle.
- `done` out NUM_REQ: one-cycle pulse to the owner when its digest is available.
- `digest` out DIGEST_WIDTH: latched digest of the last completed message.
- `err` out 1: sticky protocol-error flag.
- `hash_ready` in 1: engine can accept a command.
- `digest_valid` in 1: engine's final digest is valid.
- `digest_in` in DIGEST_WIDTH: engine digest.
- `init`, `next`, `final` out 1: registered one-cycle command pulses.
- `block` out BLOCK_WIDTH: registered block to the engine.
- `data_length` out DATA_LENGTH: registered length, loaded with `final`.

## Operation
- **States:** IDLE, CMD_INIT, GUARD, WAIT_RDY, BLOCK, WAIT_DIG.
- **Reset values:** state IDLE, round-robin pointer 0, all outputs 0 (`digest`, `block` and `data_length` included).
- **IDLE:**
  - Candidates are requesters with `req_valid & req_first`.
  - If any candidate exists and `hash_ready`=1, grant the first candidate at or after the pointer, wrapping modulo NUM_REQ. Go to CMD_INIT.
  - Candidates without `req_first` are ignored.
- **CMD_INIT:** `init`=1 for one cycle, then GUARD.
- **GUARD:** one cycle in which `hash_ready` is ignored. The engine drops ready the cycle after sampling a command. Next state is WAIT_RDY, or WAIT_DIG if the last command was `final`.
- **WAIT_RDY:** go to BLOCK when `hash_ready`=1.
- **BLOCK:**
  - `req_ready[owner]` = `hash_ready` (combinational); all other bits are 0.
  - On transfer, register `block`.
  - If `req_last`: pulse `final` and load `data_length` from `req_length[owner]`.
  - Otherwise pulse `next`.
  - Then go to GUARD.
- **Single-block message:** first and last on the same block produces `init` followed by `final`.
- **WAIT_DIG:**
  - On `digest_valid`, latch `digest_in` into `digest` and pulse `done[owner]` on the next cycle.
  - Clear `grant`, set the pointer to owner+1 (modulo NUM_REQ), return to IDLE.
- **Grant hold:** the owner keeps the grant until its digest completes. If it deasserts `req_valid` mid-message, the arbiter waits indefinitely.
- **`err` set conditions** (cleared only by reset):
  - An accepted non-first block carries `req_first`=1. The block is still processed as a continuation.
  - `digest_valid`=1 outside WAIT_DIG. The digest is ignored.
  - `hash_ready`=0 in a cycle where a command pulse is high.

## Timing
- **IDLE → init:** candidate and `hash_ready` at cycle t give `grant` and `init` registered at t+1, and GUARD at t+2.
- **Accept → command:** transfer at cycle t gives `block`/`next`/`final` at t+1. The earliest next transfer is t+3.
- **Digest:** `digest_valid` at cycle t gives `digest` and `done` at t+1 and IDLE at t+1. A new grant is possible at t+1, so a new `init` is possible at t+2.
- **Simultaneous requests:** pointer priority decides. The loser waits at most NUM_REQ−1 messages.
- **Reset mid-message:** immediate return to IDLE, no `done`. The requester must restart with `req_first`.

## Test plan
- **Single requester, 1-block message** (req0 first=last, length=64): `init` → `final` with `data_length`=64. `digest_valid` with `digest_in`=0xA5… gives `done[0]` one cycle later and `digest`=0xA5….
- **Multi-block** (req1, 3 blocks): exactly `init`, `next`, `next`, `final`. `grant`=4'b0010 is held throughout and `req_ready[0,2,3]` stay 0.
- **Fairness:** all four requesters present single-block messages continuously with the pointer at 0. Grant order is 0,1,2,3,0, and each message completes before the next `init`.
- **Stalls:** `hash_ready` held low 5 cycles after each command and `req_valid` dropped 3 cycles mid-message. No command is issued while not ready, the grant is held, and blocks arrive in order.
- **Errors:** `digest_valid` in IDLE, then `req_first` on a second block. `err` rises and stays 1; the message still completes.
- **Reset during WAIT_DIG:** all outputs 0, `done` never pulses, and the pointer is 0.
